instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of first instruction word written.
REQ-002 Parameter DEPTH, default 32, maximum number of words written per program.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-low.
REQ-005 req_valid_i  in  1  encode request present.
REQ-006 req_ready_o  out  1  encoder can accept request this cycle.
REQ-007 req_kind_i  in  3  instruction class: 0 R-type, 1 beq, 2 bne, 3 addi, 4 addiu, 5 ori, 6 lui, 7 illegal.
REQ-008 req_rs_i / req_rt_i / req_rd_i  in  5 each  register fields.
REQ-009 req_shamt_i  in  5; req_funct_i  in  6  R-type fields.
REQ-010 req_imm_i  in  16  immediate or branch offset.
REQ-011 req_last_i  in  1  request is final instruction of program.
REQ-012 start_i  in  1  rearm pulse; honoured only in DONE.
REQ-013 mem_we_o  out  1; mem_addr_o  out  32; mem_data_o  out  32  instruction-memory write port.
REQ-014 mem_ack_i  in  1  memory accepted current write.
REQ-015 count_o  out  clog2(DEPTH)+1  words written since rearm; done_o  out  1; full_o  out  1; err_o  out  1 sticky.

Function
REQ-016 FSM states IDLE, WRITE, DONE; req_ready_o SHALL be 1 only in IDLE.
REQ-017 Accept = req_valid_i & req_ready_o; legal kind -> WRITE next cycle with word, address registered.
REQ-018 Opcode map: kind 0..6 -> 6'd0, 4, 5, 8, 9, 13, 15.
REQ-019 R-type word = {6'd0, rs, rt, rd, shamt, funct}; kinds 1-5 = {op, rs, rt, imm}; lui = {6'd15, 5'd0, rt, imm} (rs forced 0); rd/shamt/funct ignored for non-R.
REQ-020 mem_addr_o = BASE_ADDR + 4*count_o, 32-bit wrap-around.
REQ-021 In WRITE, mem_we_o=1 with mem_addr_o/mem_data_o stable until mem_ack_i sampled high (ack allowed on first WRITE cycle).
REQ-022 On ack: count_o increments; next state DONE if latched last flag set or new count == DEPTH, else IDLE; minimum 2 cycles per instruction.
REQ-023 full_o = (count_o == DEPTH); in DONE with full_o, requests not accepted.
REQ-024 Kind 7 accepted (handshake completes), no write, count unchanged, err_o set; state stays IDLE unless req_last_i then DONE.
REQ-025 DONE: done_o=1, ready=0; start_i clears count_o, err_o, done_o, -> IDLE next cycle; start_i ignored in IDLE/WRITE.
REQ-026 mem_ack_i outside WRITE ignored.

Reset
REQ-027 rst_i=0 at edge: state IDLE, count_o 0, mem_we_o 0, mem_addr_o BASE_ADDR, mem_data_o 0, done_o/full_o/err_o 0; req_ready_o 1 after reset released.
REQ-028 Reset during WRITE abandons write; mem_we_o low the edge reset is sampled.

Structure
REQ-029 Shared package holds opcode constants (OP_RTYPE=0, OP_BEQ=4, OP_BNE=5, OP_ADDI=8, OP_ADDIU=9, OP_ORI=13, OP_LUI=15), kind codes, FSM state encoding.
REQ-030 One combinational sub-module instr_pack: kind + fields -> 32-bit word + illegal flag.

Verification
REQ-031 R-type kind 0, rs=1 rt=2 rd=3 shamt=0 funct=0x20 -> mem_data_o=32'h00221820 at addr BASE_ADDR, count_o=1.
REQ-032 Sequence addi rs=1 rt=2 imm=5; beq rs=1 rt=2 imm=16'hFFFF; lui rs=7 rt=4 imm=16'h1234 (last) -> words 32'h20220005, 32'h1022FFFF, 32'h3C041234 at addrs 0,4,8, then done_o=1.
REQ-033 mem_ack_i delayed 3 cycles -> mem_we_o, addr, data stable 4 cycles, req_ready_o 0 throughout.
REQ-034 DEPTH=4, five requests, none last -> four writes, full_o=1, DONE, fifth never accepted; start_i -> count_o 0, addr restarts at BASE_ADDR.
REQ-035 Kind 7 request -> handshake completes, no mem_we_o, err_o=1, count_o unchanged.
REQ-036 rst_i low during WRITE -> mem_we_o 0 next edge, count_o 0, IDLE.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared constants for the MIPS-style instruction encoder: primary opcodes,
// request kind codes, FSM state encoding, the field bundle handed to the
// packer, and a kind -> opcode lookup helper.
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

   // Primary opcode field (bits 31:26)
   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_ADDIU = 6'd9;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_LUI   = 6'd15;

   // Request kind codes
   localparam logic [2:0] KIND_RTYPE   = 3'd0;
   localparam logic [2:0] KIND_BEQ     = 3'd1;
   localparam logic [2:0] KIND_BNE     = 3'd2;
   localparam logic [2:0] KIND_ADDI    = 3'd3;
   localparam logic [2:0] KIND_ADDIU   = 3'd4;
   localparam logic [2:0] KIND_ORI     = 3'd5;
   localparam logic [2:0] KIND_LUI     = 3'd6;
   localparam logic [2:0] KIND_ILLEGAL = 3'd7;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Register/immediate fields of one request
   typedef struct packed {
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
      logic [15:0] imm;
   } instr_fields_t;

   function automatic logic [5:0] kind_to_op(input logic [2:0] kind);
      logic [5:0] op;
      case (kind)
         KIND_BEQ:   op = OP_BEQ;
         KIND_BNE:   op = OP_BNE;
         KIND_ADDI:  op = OP_ADDI;
         KIND_ADDIU: op = OP_ADDIU;
         KIND_ORI:   op = OP_ORI;
         KIND_LUI:   op = OP_LUI;
         default:    op = OP_RTYPE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
// Bundles the encode-request handshake and the instruction-memory write port.
//   slave  : the encoder (consumes requests, drives the memory write port)
//   master : the requester / memory model
// Signals
//   req_valid_i, req_ready_o        request handshake
//   req_kind_i                      instruction class
//   req_rs_i/rt_i/rd_i/shamt_i      register and shift fields
//   req_funct_i, req_imm_i          function code, immediate/branch offset
//   req_last_i                      final instruction of the program
//   mem_we_o, mem_addr_o, mem_data_o  memory write request
//   mem_ack_i                       memory accepted current write
// -----------------------------------------------------------------------------
interface instr_encoder_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [2:0]  req_kind_i;
   logic [4:0]  req_rs_i;
   logic [4:0]  req_rt_i;
   logic [4:0]  req_rd_i;
   logic [4:0]  req_shamt_i;
   logic [5:0]  req_funct_i;
   logic [15:0] req_imm_i;
   logic        req_last_i;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic        mem_ack_i;

   modport slave (
      input  req_valid_i, req_kind_i, req_rs_i, req_rt_i, req_rd_i,
             req_shamt_i, req_funct_i, req_imm_i, req_last_i, mem_ack_i,
      output req_ready_o, mem_we_o, mem_addr_o, mem_data_o
   );

   modport master (
      output req_valid_i, req_kind_i, req_rs_i, req_rt_i, req_rd_i,
             req_shamt_i, req_funct_i, req_imm_i, req_last_i, mem_ack_i,
      input  req_ready_o, mem_we_o, mem_addr_o, mem_data_o
   );
endinterface

// File: rtl/instr_encoder_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Purely combinational packer: request kind + fields -> 32-bit instruction
// word and an illegal-kind flag.
// Ports
//   i_kind    : instruction class
//   i_fields  : rs/rt/rd/shamt/funct/imm bundle
//   o_word    : encoded instruction (0 for the illegal kind)
//   o_illegal : kind has no encoding
// -----------------------------------------------------------------------------
module instr_pack
   import instr_encoder_pkg::*;
(
   input  logic [2:0]    i_kind,
   input  instr_fields_t i_fields,
   output logic [31:0]   o_word,
   output logic          o_illegal
);

   always_comb begin
      o_word    = '0;
      o_illegal = 1'b0;
      case (i_kind)
         KIND_RTYPE:
            o_word = {OP_RTYPE, i_fields.rs, i_fields.rt, i_fields.rd,
                      i_fields.shamt, i_fields.funct};
         // lui has no source register; rs is forced to zero
         KIND_LUI:
            o_word = {OP_LUI, 5'd0, i_fields.rt, i_fields.imm};
         KIND_ILLEGAL:
            o_illegal = 1'b1;
         default:
            o_word = {kind_to_op(i_kind), i_fields.rs, i_fields.rt, i_fields.imm};
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Accepts encode requests one at a time, packs each into a 32-bit instruction
// and writes it to instruction memory at BASE_ADDR + 4*count. A program ends
// on the request flagged last or when DEPTH words have been written; start_i
// rearms the encoder from DONE.
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : synchronous reset, active low
//   start_i  : rearm pulse, only honoured in DONE
//   bus      : request handshake + memory write port (slave modport)
//   count_o  : words written since rearm
//   done_o   : program complete
//   full_o   : DEPTH words written
//   err_o    : sticky, an illegal kind was accepted since rearm
// -----------------------------------------------------------------------------
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 32
)(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   instr_encoder_if.slave           bus,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     done_o,
   output logic                     full_o,
   output logic                     err_o
);

   localparam int                CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(DEPTH);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_count;
   logic [31:0]      r_word;
   logic             r_last;
   logic             r_err;

   instr_fields_t    w_fields;
   logic [31:0]      w_word;
   logic             w_illegal;
   logic             w_ready;
   logic             w_accept;
   logic [CNT_W-1:0] w_count_inc;

   assign w_fields = '{rs:    bus.req_rs_i,
                       rt:    bus.req_rt_i,
                       rd:    bus.req_rd_i,
                       shamt: bus.req_shamt_i,
                       funct: bus.req_funct_i,
                       imm:   bus.req_imm_i};

   instr_pack u_pack (
      .i_kind    (bus.req_kind_i),
      .i_fields  (w_fields),
      .o_word    (w_word),
      .o_illegal (w_illegal)
   );

   assign w_ready     = (r_state == ST_IDLE);
   assign w_accept    = bus.req_valid_i & w_ready;
   assign w_count_inc = r_count + CNT_W'(1);

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_word  <= '0;
         r_last  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_illegal) begin
                     // Handshake completes but nothing is written
                     r_err <= 1'b1;
                     if (bus.req_last_i) r_state <= ST_DONE;
                  end else begin
                     r_word  <= w_word;
                     r_last  <= bus.req_last_i;
                     r_state <= ST_WRITE;
                  end
               end
            end
            ST_WRITE: begin
               if (bus.mem_ack_i) begin
                  r_count <= w_count_inc;
                  r_state <= (r_last || (w_count_inc == C_DEPTH)) ? ST_DONE : ST_IDLE;
               end
            end
            ST_DONE: begin
               if (start_i) begin
                  r_count <= '0;
                  r_err   <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready_o = w_ready;
   assign bus.mem_we_o    = (r_state == ST_WRITE);
   // Word-aligned address; the 32-bit sum wraps naturally
   assign bus.mem_addr_o  = BASE_ADDR + (32'(r_count) << 2);
   assign bus.mem_data_o  = r_word;

   assign count_o = r_count;
   assign done_o  = (r_state == ST_DONE);
   assign full_o  = (r_count == C_DEPTH);
   assign err_o   = r_err;

endmodule
